pattern_det_ctrl: RTL and testbench

PATTERN_DET_CTRL -- requirements
Module: pattern_det_ctrl

---
 rtl/pattern_det_ctrl.sv | 133 +++++++++++++
 tb/tb_pattern_det_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_det_ctrl.sv
// pattern_det_ctrl: serial pattern detector with a bounded detection window.
// A window is opened by start (pattern and length latched), consumes one bit
// per qualified cycle, reports each occurrence with a combinational match
// pulse, counts occurrences and signals completion with a one-cycle done.
// Optional feature macro: PATTERN_DET_OVERLAP_EN
//   defined   -> overlapping occurrences are counted
//   undefined -> after a match, PAT_W fresh bits are needed for the next one
module pattern_det_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pat,
  input  logic [CNT_W-1:0] len,
  input  logic             in,
  input  logic             in_valid,
  input  logic             abort,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done
);

  // Fill counter only has to reach PAT_W-1 (history fully primed).
  localparam int FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [PAT_W-1:0]   pat_q;
  logic [CNT_W-1:0]   len_q;
  logic [PAT_W-2:0]   hist;
  logic [FILL_W-1:0]  fill;
  logic [CNT_W-1:0]   bit_cnt;

  logic [PAT_W-1:0]   cand;
  logic [CNT_W:0]     bit_num;
  logic               accept;
  logic               consume;

  // Candidate word: the previous PAT_W-1 bits followed by the current bit.
  assign cand    = {hist, in};
  // One-based number of the bit being consumed this cycle (extra MSB avoids wrap).
  assign bit_num = {1'b0, bit_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign accept  = (state == IDLE) && start;
  assign consume = (state == RUN) && in_valid && !abort;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and Mealy/Moore outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    match     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        match = in_valid && !abort && (fill == FILL_FULL) && (cand == pat_q);
        if (abort) begin
          state_nxt = IDLE;
        end else if (in_valid && (bit_num == {1'b0, len_q})) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Window datapath: latched config, history, fill/bit counters, match count.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q     <= '0;
      len_q     <= '0;
      hist      <= '0;
      fill      <= '0;
      bit_cnt   <= '0;
      match_cnt <= '0;
    end else if (accept) begin
      pat_q     <= pat;
      len_q     <= len;
      hist      <= '0;
      fill      <= '0;
      bit_cnt   <= '0;
      match_cnt <= '0;
    end else if (consume) begin
      hist    <= cand[PAT_W-2:0];
      bit_cnt <= bit_num[CNT_W-1:0];
      if (match && (match_cnt != {CNT_W{1'b1}})) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end
`ifdef PATTERN_DET_OVERLAP_EN
      if (fill != FILL_FULL) begin
        fill <= fill + FILL_W'(1);
      end
`else
      if (match) begin
        fill <= '0;
      end else if (fill != FILL_FULL) begin
        fill <= fill + FILL_W'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_pattern_det_ctrl.sv
// Testbench for pattern_det_ctrl: directed scenarios followed by randomized
// windows, all checked against a queue-based reference model that derives
// matches directly from the consumed bit stream.
module tb_pattern_det_ctrl;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
`ifdef PATTERN_DET_OVERLAP_EN
  localparam bit OVL    = 1'b1;
  localparam int EXP_S1 = 3;
`else
  localparam bit OVL    = 1'b0;
  localparam int EXP_S1 = 2;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [PAT_W-1:0] pat;
  logic [CNT_W-1:0] len;
  logic             in;
  logic             in_valid;
  logic             abort;
  logic             busy;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             done;

  always #5 clk = ~clk;

  pattern_det_ctrl #(
    .PAT_W(PAT_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pat      (pat),
    .len      (len),
    .in       (in),
    .in_valid (in_valid),
    .abort    (abort),
    .busy     (busy),
    .match    (match),
    .match_cnt(match_cnt),
    .done     (done)
  );

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;
  int dones  = 0;

  // Reference model: window open flag, pending done, consumed bits of the
  // current window, index (1-based) of the last counted match.
  bit             m_active = 1'b0;
  bit             m_done   = 1'b0;
  int             m_cnt    = 0;
  int             m_len    = 0;
  logic [PAT_W-1:0] m_pat  = '0;
  int             m_bits[$];
  int             m_last   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A bit b consumed now matches when the last PAT_W consumed bits (b last)
  // equal the pattern and, in non-overlap mode, none of them belonged to a
  // previously counted occurrence.
  function automatic bit model_match(input logic b);
    int n;
    int w;
    if (!m_active || !in_valid || abort) return 1'b0;
    n = m_bits.size() + 1;
    if (n < PAT_W) return 1'b0;
    if (!OVL && ((n - m_last) < PAT_W)) return 1'b0;
    w = 0;
    for (int i = n - PAT_W; i < n - 1; i++) w = (w << 1) | m_bits[i];
    w = (w << 1) | int'(b);
    return (w == int'(m_pat));
  endfunction

  task automatic cyc(input string tag, input bit s, input logic [PAT_W-1:0] p,
                     input logic [CNT_W-1:0] l, input bit b, input bit v,
                     input bit a, input bit r);
    bit em;
    start = s; pat = p; len = l; in = b; in_valid = v; abort = a; rst = r;
    #2;
    em = model_match(b);
    if (!r) chk({tag, ":match"}, 32'(match), 32'(em));
    if (match === 1'b1) pulses++;
    @(posedge clk);
    if (r) begin
      m_active = 1'b0; m_done = 1'b0; m_cnt = 0; m_len = 0; m_pat = '0;
      m_bits.delete(); m_last = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (!m_active) begin
      if (s) begin
        m_pat = p; m_len = int'(l); m_bits.delete(); m_last = 0; m_cnt = 0;
        if (l == '0) m_done = 1'b1;
        else m_active = 1'b1;
      end
    end else if (a) begin
      m_active = 1'b0;
    end else if (v) begin
      m_bits.push_back(int'(b));
      if (em) begin
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        m_last = m_bits.size();
      end
      if (m_bits.size() == m_len) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
    #1;
    if (done === 1'b1) dones++;
    chk({tag, ":busy"}, 32'(busy), 32'(m_active));
    chk({tag, ":done"}, 32'(done), 32'(m_done));
    chk({tag, ":match_cnt"}, 32'(match_cnt), 32'(m_cnt));
  endtask

  task automatic send(input string tag, input logic [15:0] stream, input int nbits);
    logic [15:0] s;
    s = stream;
    for (int i = nbits - 1; i >= 0; i--) cyc(tag, 0, '0, '0, s[i], 1, 0, 0);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 0, '0, '0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset and reset-state values
    cyc("rst", 0, '0, '0, 0, 0, 0, 1);
    cyc("rst", 0, '0, '0, 0, 0, 0, 1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    idle("idle", 2);

    // 1101 over 1101101101
    pulses = 0; dones = 0;
    cyc("s1", 1, 4'b1101, 8'd10, 0, 0, 0, 0);
    send("s1", 16'b1101101101, 10);
    idle("s1", 3);
    chk("s1_pulses", 32'(pulses), 32'(EXP_S1));
    chk("s1_cnt", 32'(match_cnt), 32'(EXP_S1));
    chk("s1_dones", 32'(dones), 32'd1);

    // Gap of three invalid cycles inside the window
    pulses = 0; dones = 0;
    cyc("gap", 1, 4'b1101, 8'd6, 0, 0, 0, 0);
    send("gap", 16'b11, 2);
    cyc("gap", 0, '0, '0, 1, 0, 0, 0);
    cyc("gap", 0, '0, '0, 0, 0, 0, 0);
    cyc("gap", 0, '0, '0, 1, 0, 0, 0);
    send("gap", 16'b0101, 4);
    idle("gap", 3);
    chk("gap_pulses", 32'(pulses), 32'd1);
    chk("gap_cnt", 32'(match_cnt), 32'd1);
    chk("gap_dones", 32'(dones), 32'd1);

    // Abort together with the completing bit
    pulses = 0; dones = 0;
    cyc("abt", 1, 4'b1101, 8'd10, 0, 0, 0, 0);
    send("abt", 16'b110, 3);
    cyc("abt", 0, '0, '0, 1, 1, 1, 0);
    chk("abt_busy", 32'(busy), 32'd0);
    idle("abt", 3);
    chk("abt_pulses", 32'(pulses), 32'd0);
    chk("abt_cnt", 32'(match_cnt), 32'd0);
    chk("abt_dones", 32'(dones), 32'd0);

    // Zero-length window
    dones = 0;
    cyc("len0", 1, 4'b1111, 8'd0, 0, 0, 0, 0);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    idle("len0", 2);
    chk("len0_dones", 32'(dones), 32'd1);
    chk("len0_cnt", 32'(match_cnt), 32'd0);

    // Reset mid-window after one match, then a clean restart
    cyc("mrst", 1, 4'b1101, 8'd10, 0, 0, 0, 0);
    send("mrst", 16'b11011, 5);
    chk("mrst_pre_cnt", 32'(match_cnt), 32'd1);
    cyc("mrst", 0, '0, '0, 1, 1, 1, 1);
    chk("mrst_cnt", 32'(match_cnt), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    pulses = 0; dones = 0;
    cyc("mrst", 1, 4'b1011, 8'd6, 0, 0, 0, 0);
    cyc("mrst", 0, '0, '0, 1, 1, 0, 0);
    cyc("mrst", 1, 4'b0000, 8'd2, 0, 1, 0, 0);
    send("mrst", 16'b1100, 4);
    idle("mrst", 2);
    chk("mrst_pulses", 32'(pulses), 32'd1);
    chk("mrst_new_cnt", 32'(match_cnt), 32'd1);
    chk("mrst_dones", 32'(dones), 32'd1);

    // Randomized traffic
    for (int k = 0; k < 4000; k++) begin
      bit rs, ra, rr, rv;
      logic [PAT_W-1:0] rp;
      logic [CNT_W-1:0] rl;
      rs = ($urandom_range(0, 3) == 0);
      rp = PAT_W'($urandom);
      if ($urandom_range(0, 3) == 0) rp = {PAT_W{1'b1}};
      rl = CNT_W'($urandom_range(0, 24));
      rv = ($urandom_range(0, 3) != 0);
      ra = ($urandom_range(0, 49) == 0);
      rr = ($urandom_range(0, 199) == 0);
      cyc("rnd", rs, rp, rl, ($urandom_range(0, 2) != 0), rv, ra, rr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
